// File: rtl/riu_pkg.sv
// Shared regfile-writeback definitions: register address width and the buffered load entry.
package riu_pkg;

    localparam int REG_AW = 5;
    localparam int NREGS  = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              kill;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Circular load-writeback buffer with kill-by-rd so younger ALU writes can squash stale loads.
import riu_pkg::*;

module wb_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  wb_entry_t                     push_entry,
    input  logic                          pop,
    input  logic                          kill_en,
    input  logic [REG_AW-1:0]             kill_rd,
    output wb_entry_t                     head,
    output logic                          full,
    output logic                          empty,
    output logic [DEPTH-1:0]              entry_live,
    output logic [DEPTH-1:0][REG_AW-1:0]  entry_rd
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t [DEPTH-1:0] mem;
    logic      [DEPTH-1:0] vld;
    logic      [PW-1:0]    wptr, rptr;
    logic      [PW:0]      count;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rptr];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_live[i] = vld[i] && !mem[i].kill;
            entry_rd[i]   = mem[i].rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            vld   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            // Kill is applied before the push so a same-cycle younger load stays live.
            for (int i = 0; i < DEPTH; i++)
                if (kill_en && vld[i] && mem[i].rd == kill_rd)
                    mem[i].kill <= 1'b1;
            if (pop) begin
                vld[rptr] <= 1'b0;
                rptr      <= rptr + PW'(1);
            end
            if (push) begin
                mem[wptr] <= push_entry;
                vld[wptr] <= 1'b1;
                wptr      <= wptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Regfile write-port master: ALU writes win, buffered loads drain in order, pending mask for decode stalls.
import riu_pkg::*;

module wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [XLEN-1:0]  alu_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [4:0]       ld_rd,
    input  logic [XLEN-1:0]  ld_data,
    output logic             we,
    output logic [4:0]       writeaddr,
    output logic [XLEN-1:0]  writedata,
    output logic [NREGS-1:0] pending_mask
);

    logic                         alu_eff, push, pop, full, empty;
    wb_entry_t                    head, push_entry;
    logic [DEPTH-1:0]             entry_live;
    logic [DEPTH-1:0][REG_AW-1:0] entry_rd;

    assign alu_eff    = alu_valid && (alu_rd != '0);
    assign ld_ready   = !full;
    assign push       = ld_valid && ld_ready;
    assign pop        = !alu_eff && !empty;
    assign push_entry = '{rd: ld_rd, data: DATA_W'(ld_data), kill: 1'b0};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (alu_eff),
        .kill_rd    (alu_rd),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .entry_live (entry_live),
        .entry_rd   (entry_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we        <= 1'b0;
            writeaddr <= '0;
            writedata <= '0;
        end else if (alu_eff) begin
            we        <= 1'b1;
            writeaddr <= alu_rd;
            writedata <= alu_data;
        end else if (pop) begin
            // Killed or rd==0 entries still take the port for one cycle, just without a write.
            we        <= !head.kill && (head.rd != '0);
            writeaddr <= head.rd;
            writedata <= XLEN'(head.data);
        end else begin
            we        <= 1'b0;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (entry_live[i] && entry_rd[i] != '0)
                pending_mask[entry_rd[i]] = 1'b1;
    end

endmodule
